// File: rtl/scan_display6.sv
// Time-multiplexed 6-digit common-anode 7-segment driver with a blanking gap between digits.
// Each slot is DIV cycles: BLANK_CYC dark cycles, then the selected digit is lit.
module scan_display6 #(
    parameter int unsigned DIV       = 1000,
    parameter int unsigned BLANK_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd,
    input  logic [5:0] dp_mask,
    output logic [3:0] sel,
    output logic [5:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [0:0] BLANK = 1'b0;
    localparam logic [0:0] SHOW  = 1'b1;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0] DIV_LAST   = CW'(DIV - 1);

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    sel_d;
    logic [5:0]    onehot;
    logic [5:0]    an_d;
    logic [6:0]    seg_d, seg_dec;
    logic          dp_d;
    logic          lit;

    // Active-low gfedcba; 4'hF and anything unlisted stay dark.
    always_comb begin
        seg_dec = 7'b1111111;
        case (bcd)
            4'h0: seg_dec = 7'b1000000;
            4'h1: seg_dec = 7'b1111001;
            4'h2: seg_dec = 7'b0100100;
            4'h3: seg_dec = 7'b0110000;
            4'h4: seg_dec = 7'b0011001;
            4'h5: seg_dec = 7'b0010010;
            4'h6: seg_dec = 7'b0000010;
            4'h7: seg_dec = 7'b1111000;
            4'h8: seg_dec = 7'b0000000;
            4'h9: seg_dec = 7'b0010000;
            4'hA: seg_dec = 7'b0001000;
            4'hB: seg_dec = 7'b0000011;
            4'hC: seg_dec = 7'b1000110;
            4'hD: seg_dec = 7'b0100001;
            4'hE: seg_dec = 7'b0000110;
            default: seg_dec = 7'b1111111;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        sel_d   = sel;
        if (state_q == BLANK) begin
            if (cnt_q == BLANK_LAST) begin
                state_d = SHOW;
            end
        end else if (cnt_q == DIV_LAST) begin
            // sel only moves on BLANK entry so the mux settles before the next SHOW
            state_d = BLANK;
            cnt_d   = '0;
            sel_d   = (sel == 4'd5) ? 4'd0 : sel + 4'd1;
        end

        lit    = (state_d == SHOW);
        onehot = 6'b000001 << sel;
        an_d   = lit ? ~onehot : 6'h3F;
        seg_d  = lit ? seg_dec : 7'h7F;
        dp_d   = lit ? ~|(dp_mask & onehot) : 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            sel     <= 4'd0;
            an      <= 6'h3F;
            seg     <= 7'h7F;
            dp      <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel     <= sel_d;
            an      <= an_d;
            seg     <= seg_d;
            dp      <= dp_d;
        end
    end

endmodule

// File: tb/tb_scan_display6.sv
// Directed bench for scan_display6 with DIV=8, BLANK_CYC=2 and a behavioural 6:1 digit mux.
module tb_scan_display6;

    localparam int unsigned DIV       = 8;
    localparam int unsigned BLANK_CYC = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] bcd;
    logic [5:0] dp_mask = 6'b0;
    logic [3:0] sel;
    logic [5:0] an;
    logic [6:0] seg;
    logic       dp;

    logic [3:0] digits [8];
    logic [6:0] seg_tab [16];
    logic [5:0] an_tab [6];

    int tests = 0;
    int fails = 0;

    scan_display6 #(
        .DIV       (DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bcd     (bcd),
        .dp_mask (dp_mask),
        .sel     (sel),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    always #5 clk = ~clk;

    // Digit mux model; slots 6 and 7 read as blank
    always_comb bcd = digits[sel[2:0]];

    task automatic set_digits(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                              input logic [3:0] d3, input logic [3:0] d4, input logic [3:0] d5);
        digits[0] = d0; digits[1] = d1; digits[2] = d2;
        digits[3] = d3; digits[4] = d4; digits[5] = d5;
        digits[6] = 4'hF; digits[7] = 4'hF;
    endtask

    // Ends at the falling edge of cycle 1 after the reset edge
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        set_digits(4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
        dp_mask = 6'b0;
        do_reset();
        tests++; if (sel !== 4'd0) begin fails++; $display("FAIL reset_sel got %h want 0", sel); end
        tests++; if (an !== 6'h3F) begin fails++; $display("FAIL reset_an got %h want 3f", an); end
        tests++; if (seg !== 7'h7F) begin fails++; $display("FAIL reset_seg got %h want 7f", seg); end
        tests++; if (dp !== 1'b1) begin fails++; $display("FAIL reset_dp got %b want 1", dp); end
    endtask

    task automatic test_first_slots();
        logic [5:0] ea;
        logic [6:0] es;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            if (k <= 2 || k == 9 || k == 10) begin
                ea = 6'h3F; es = 7'h7F;
            end else if (k <= 8) begin
                ea = 6'h3E; es = 7'b1000000;
            end else begin
                ea = 6'h3D; es = 7'b1111001;
            end
            tests++;
            if (an !== ea) begin fails++; $display("FAIL first_an cyc %0d got %h want %h", k, an, ea); end
            tests++;
            if (seg !== es) begin fails++; $display("FAIL first_seg cyc %0d got %b want %b", k, seg, es); end
            if (k == 9) begin
                tests++;
                if (sel !== 4'd1) begin fails++; $display("FAIL first_sel9 got %h want 1", sel); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_free_run();
        int s, p;
        logic [5:0] ea;
        do_reset();
        for (int k = 1; k <= 100 * 6 * 8; k++) begin
            s  = ((k - 1) / 8) % 6;
            p  = (k - 1) % 8 + 1;
            ea = (p <= 2) ? 6'h3F : an_tab[s];
            tests++;
            if (sel !== 4'(s)) begin fails++; $display("FAIL run_sel cyc %0d got %h want %0d", k, sel, s); end
            tests++;
            if (sel > 4'd5) begin fails++; $display("FAIL run_sel_range cyc %0d got %h want <6", k, sel); end
            tests++;
            if ($countones(~an) > 1) begin
                fails++; $display("FAIL run_onehot cyc %0d an %h want <=1 low", k, an);
            end
            tests++;
            if (an !== ea) begin fails++; $display("FAIL run_an cyc %0d got %h want %h", k, an, ea); end
            @(negedge clk);
        end
    endtask

    task automatic test_blank_dp();
        int s, p;
        logic [5:0] ea;
        logic [6:0] es;
        logic       ed;
        set_digits(4'd0, 4'd1, 4'd2, 4'hF, 4'd4, 4'd5);
        dp_mask = 6'b001000;
        do_reset();
        for (int k = 1; k <= 48; k++) begin
            s = (k - 1) / 8;
            p = (k - 1) % 8 + 1;
            if (p <= 2) begin
                ea = 6'h3F; es = 7'h7F; ed = 1'b1;
            end else begin
                ea = an_tab[s]; es = seg_tab[digits[s]]; ed = (s == 3) ? 1'b0 : 1'b1;
            end
            tests++;
            if (an !== ea) begin fails++; $display("FAIL dp_an cyc %0d got %h want %h", k, an, ea); end
            tests++;
            if (seg !== es) begin fails++; $display("FAIL dp_seg cyc %0d got %b want %b", k, seg, es); end
            tests++;
            if (dp !== ed) begin fails++; $display("FAIL dp_dp cyc %0d got %b want %b", k, dp, ed); end
            @(negedge clk);
        end
        dp_mask = 6'b0;
    endtask

    task automatic test_midshow_change();
        set_digits(4'd0, 4'd1, 4'd3, 4'd3, 4'd4, 4'd5);
        do_reset();
        for (int k = 1; k < 21; k++) @(negedge clk);
        tests++;
        if (seg !== 7'b0110000) begin fails++; $display("FAIL mid_before got %b want 0110000", seg); end
        tests++;
        if (an !== 6'h3B) begin fails++; $display("FAIL mid_an_before got %h want 3b", an); end
        digits[2] = 4'd8;
        @(negedge clk);
        tests++;
        if (seg !== 7'b0000000) begin fails++; $display("FAIL mid_after got %b want 0000000", seg); end
        tests++;
        if (an !== 6'h3B) begin fails++; $display("FAIL mid_an_after got %h want 3b", an); end
    endtask

    task automatic test_reset_mid();
        set_digits(4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
        do_reset();
        for (int k = 1; k < 37; k++) @(negedge clk);
        tests++;
        if (an !== 6'h2F) begin fails++; $display("FAIL rmid_pre_an got %h want 2f", an); end
        do_reset();
        tests++; if (an !== 6'h3F) begin fails++; $display("FAIL rmid_an got %h want 3f", an); end
        tests++; if (seg !== 7'h7F) begin fails++; $display("FAIL rmid_seg got %h want 7f", seg); end
        tests++; if (sel !== 4'd0) begin fails++; $display("FAIL rmid_sel got %h want 0", sel); end
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            tests++;
            if (an !== ((k <= 2) ? 6'h3F : 6'h3E)) begin
                fails++; $display("FAIL rmid_slot_an cyc %0d got %h", k, an);
            end
            tests++;
            if (seg !== ((k <= 2) ? 7'h7F : 7'b1000000)) begin
                fails++; $display("FAIL rmid_slot_seg cyc %0d got %b", k, seg);
            end
        end
    endtask

    task automatic test_decode_sweep();
        for (int v = 0; v < 16; v++) begin
            digits[0] = 4'(v);
            do_reset();
            @(negedge clk);
            @(negedge clk);
            tests++;
            if (seg !== seg_tab[v]) begin
                fails++; $display("FAIL decode %h got %b want %b", v, seg, seg_tab[v]);
            end
            tests++;
            if (an !== 6'h3E) begin fails++; $display("FAIL decode_an %h got %h want 3e", v, an); end
        end
    endtask

    initial begin
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001; seg_tab[2]  = 7'b0100100;
        seg_tab[3]  = 7'b0110000; seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000; seg_tab[8]  = 7'b0000000;
        seg_tab[9]  = 7'b0010000; seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
        seg_tab[12] = 7'b1000110; seg_tab[13] = 7'b0100001; seg_tab[14] = 7'b0000110;
        seg_tab[15] = 7'b1111111;
        an_tab[0] = 6'h3E; an_tab[1] = 6'h3D; an_tab[2] = 6'h3B;
        an_tab[3] = 6'h37; an_tab[4] = 6'h2F; an_tab[5] = 6'h1F;
        set_digits(4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5);

        test_reset();
        test_first_slots();
        test_free_run();
        test_blank_dp();
        test_midshow_change();
        test_reset_mid();
        test_decode_sweep();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
